// File: rtl/serial_link_pkg.sv
// Shared definitions for the NeXT keyboard/sound serial link (transmit and receive sides).
package serial_link_pkg;

  // Data bits carried by one frame; the receiver sizes its shift register from this too.
  localparam int unsigned FRAME_W = 40;

  // Shortest low gap between frames that a receiver can resynchronise on.
  localparam int unsigned MIN_GAP = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StGap
  } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full/empty come from pointers alone.
module tx_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  // Pointer update; wrap bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
    end
  end

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/serial_transmitter.sv
// Parallel-to-serial frame transmitter: start bit '1', FRAME_W data bits MSB first, then a low gap.
module serial_transmitter #(
  parameter int unsigned FRAME_W       = serial_link_pkg::FRAME_W,
  parameter int unsigned GAP_CYCLES    = serial_link_pkg::MIN_GAP,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned RESET_HOLDOFF = 42
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               so,
  output logic               busy,
  output logic               frame_done
);

  import serial_link_pkg::*;

  localparam int unsigned BitCntW = $clog2(FRAME_W + 1);
  localparam int unsigned GapCntW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned HoldW   = (RESET_HOLDOFF > 0) ? $clog2(RESET_HOLDOFF + 1) : 1;

  tx_state_e            state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GapCntW-1:0]   gap_cnt_q, gap_cnt_d;
  logic                 so_q, so_d;
  logic                 frame_done_q, frame_done_d;
  logic [HoldW-1:0]     holdoff_q;

  logic [FRAME_W-1:0]   fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;

  // Ready depends only on registered state, so a full FIFO blocks pushes even while popping.
  assign tx_ready   = (holdoff_q == '0) && !fifo_full;
  assign push       = tx_valid && tx_ready;
  assign so         = so_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

  tx_fifo #(
    .Width (FRAME_W),
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Post-reset holdoff gives a peer receiver left mid-frame time to run out its bit count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff_q <= HoldW'(RESET_HOLDOFF);
    end else if (holdoff_q != '0) begin
      holdoff_q <= holdoff_q - HoldW'(1);
    end
  end

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    so_d         = 1'b0;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          so_d    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        so_d      = shift_q[FRAME_W-1];
        shift_d   = shift_q << 1;
        bit_cnt_d = BitCntW'(1);
        state_d   = StData;
      end
      StData: begin
        if (bit_cnt_q == BitCntW'(FRAME_W)) begin
          gap_cnt_d    = GapCntW'(1);
          frame_done_d = 1'b1;
          state_d      = StGap;
        end else begin
          so_d      = shift_q[FRAME_W-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapCntW'(GAP_CYCLES)) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            so_d    = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GapCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state; reset drops so immediately and abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      so_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      so_q         <= so_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: frame-position line model, loopback decoder and directed pins.
module tb_serial_transmitter;

  localparam int FW        = 40;
  localparam int GAP       = 2;
  localparam int DEPTH     = 2;
  localparam int HOLD      = 42;
  localparam int FRAME_LEN = 1 + FW + GAP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, so, busy, frame_done;

  int checks = 0;
  int failures = 0;

  serial_transmitter #(
    .FRAME_W       (FW),
    .GAP_CYCLES    (GAP),
    .FIFO_DEPTH    (DEPTH),
    .RESET_HOLDOFF (HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .so         (so),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame occupies FRAME_LEN line cycles, numbered 1..FRAME_LEN by m_pos
  // (0 = line idle). Words queue in m_fifo; a new frame may begin once the previous is over.
  logic [FW-1:0] m_fifo [$];
  logic [FW-1:0] sent_q [$];
  logic [FW-1:0] m_cur = '0;
  int            m_pos = 0;
  int            m_hold = HOLD;

  function automatic bit mrdy();
    return (m_hold == 0) && (m_fifo.size() < DEPTH);
  endfunction

  function automatic logic exp_so();
    if (m_pos == 1) return 1'b1;
    if (m_pos >= 2 && m_pos <= FW + 1) return m_cur[FW + 1 - m_pos];
    return 1'b0;
  endfunction

  initial forever begin
    bit push;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_fifo.delete();
      sent_q.delete();
      m_pos  = 0;
      m_hold = HOLD;
    end else begin
      push = tx_valid && mrdy();
      if (m_pos == 0 || m_pos == FRAME_LEN) begin
        if (m_fifo.size() > 0) begin
          m_cur = m_fifo.pop_front();
          m_pos = 1;
        end else begin
          m_pos = 0;
        end
      end else begin
        m_pos++;
      end
      if (push) begin
        m_fifo.push_back(tx_data);
        sent_q.push_back(tx_data);
      end
      if (m_hold > 0) m_hold--;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    check("so", so, exp_so());
    check("tx_ready", tx_ready, mrdy());
    check("busy", busy, (m_pos != 0) || (m_fifo.size() != 0));
    check("frame_done", frame_done, m_pos == FW + 2);
  end

  // Loopback receiver: idle-low line, a '1' starts a frame, then FW bits MSB first.
  bit            rx_active = 1'b0;
  int            rx_n = 0;
  int            rx_cyc = 0;
  logic [FW-1:0] rx_word = '0;
  int            start_q [$];

  initial forever begin
    @(negedge clk);
    rx_cyc++;
    if (!rst_n) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (so === 1'b1) begin
        rx_active = 1'b1;
        rx_n      = 0;
        start_q.push_back(rx_cyc);
      end
    end else begin
      rx_word = {rx_word[FW-2:0], so};
      rx_n++;
      if (rx_n == FW) begin
        rx_active = 1'b0;
        if (sent_q.size() == 0) check("rx_extra_frame", 64'(rx_word), 64'hx);
        else check("rx_word", 64'(rx_word), 64'(sent_q.pop_front()));
      end
    end
  end

  function automatic logic [FW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic send(input logic [FW-1:0] w);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = w;
    while (!mrdy() && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", n < 200, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_pos != 0 || m_fifo.size() != 0 || rx_active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 3000, 1'b1);
  endtask

  // Called on the negedge where rst_n is released: counts ready-low cycles from there.
  task automatic holdoff_check(input string nm);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(nm, n, HOLD);
  endtask

  initial begin
    logic [FRAME_LEN-1:0] bits;
    logic [FRAME_LEN-1:0] fd;
    int n;
    int acc;

    repeat (3) @(negedge clk);
    check("reset_so", so, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = rand_word();
    holdoff_check("holdoff_after_reset");
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();

    // Directed frame: whole line pattern pinned as a literal.
    send(40'hA5_0000_0F01);
    bits = '0;
    fd   = '0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      bits = {bits[FRAME_LEN-2:0], so};
      fd   = {fd[FRAME_LEN-2:0], frame_done};
    end
    check("a5_line", 64'(bits), 64'({1'b1, 40'hA5_0000_0F01, 2'b00}));
    check("a5_frame_done", 64'(fd), 64'd2);
    wait_idle();

    // Three words back-to-back: frames must start 43 cycles apart.
    start_q.delete();
    for (int i = 0; i < 3; i++) send(rand_word());
    wait_idle();
    check("b2b_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("b2b_period_0", start_q[1] - start_q[0], 43);
      check("b2b_period_1", start_q[2] - start_q[1], 43);
    end
    check("busy_low_after", busy, 1'b0);

    // Loopback corner words.
    send(40'h00_0000_0001);
    send(40'hFF_FFFF_FFFF);
    send(40'h80_0000_0000);
    wait_idle();

    // Reset while data bit 20 is on the line.
    send(rand_word());
    n = 0;
    while (m_pos != 21 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit20", n < 200, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_so", so, 1'b0);
    check("midreset_ready", tx_ready, 1'b0);
    check("midreset_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    holdoff_check("holdoff_after_midreset");
    send(rand_word());
    wait_idle();

    // Random valid toggling and data churn; the scoreboard checks each accepted word.
    acc = 0;
    n   = 0;
    while (acc < 16 && n < 5000) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = rand_word();
      if (tx_valid && mrdy()) acc++;
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    check("random_accept_timeout", n < 5000, 1'b1);
    wait_idle();
    check("all_delivered", sent_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
